// File: rtl/led_status_ctrl.sv
// led_status_ctrl: per-LED display-mode sequencer for registered indicator cells.
// Holds one display mode per LED, written over a valid/ready port. A shared
// prescaler produces a tick strobe and a 3-bit blink phase counter. Each LED
// gets one registered data bit, so the indicator cells need no timing logic.
// Optional feature: define LED_CTRL_DIM_EN to enable mode 5 (DIM, 25 % PWM).

// Per-LED lane: stored mode, one-shot pulse counter and registered LED bit.
module led_lane #(
  parameter int PulseTicks = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_i,      // accepted write with a legal mode, for this lane
  input  logic [2:0] wr_mode_i,
  input  logic       tick_i,
  input  logic       slow_i,    // slow blink phase
  input  logic       fast_i,    // fast blink phase
`ifdef LED_CTRL_DIM_EN
  input  logic       dim_i,     // 25 % duty PWM phase
`endif
  output logic       busy_o,
  output logic       led_o
);

  localparam logic [2:0] MOFF   = 3'd0;
  localparam logic [2:0] MON    = 3'd1;
  localparam logic [2:0] MSLOW  = 3'd2;
  localparam logic [2:0] MFAST  = 3'd3;
  localparam logic [2:0] MPULSE = 3'd4;
`ifdef LED_CTRL_DIM_EN
  localparam logic [2:0] MDIM   = 3'd5;
`endif

  logic [2:0] mode_q;
  logic [7:0] pcnt_q;
  logic       led_d;
  logic       led_q;

  // Mode and pulse counter; a write on the same cycle as a tick takes priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= MOFF;
      pcnt_q <= 8'd0;
    end else if (wr_i) begin
      mode_q <= wr_mode_i;
      pcnt_q <= (wr_mode_i == MPULSE) ? 8'(PulseTicks) : 8'd0;
    end else if (tick_i && (pcnt_q != 8'd0)) begin
      if (pcnt_q == 8'd1) begin
        mode_q <= MOFF;
        pcnt_q <= 8'd0;
      end else begin
        pcnt_q <= pcnt_q - 8'd1;
      end
    end
  end

  // Decode the current mode into the next LED value.
  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      MON:    led_d = 1'b1;
      MSLOW:  led_d = slow_i;
      MFAST:  led_d = fast_i;
      MPULSE: led_d = 1'b1;
`ifdef LED_CTRL_DIM_EN
      MDIM:   led_d = dim_i;
`endif
      default: led_d = 1'b0;
    endcase
  end

  // Registered LED bit feeding the indicator cell.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) led_q <= 1'b0;
    else         led_q <= led_d;
  end

  assign busy_o = (pcnt_q != 8'd0);
  assign led_o  = led_q;

endmodule

// Top: prescaler, blink phase counter, handshake and the lane array.
module led_status_ctrl #(
  parameter int NumLeds       = 4,
  parameter int PrescaleWidth = 8,
  parameter int PulseTicks    = 8,
  localparam int IdxW         = $clog2(NumLeds)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [IdxW-1:0]    cfg_idx_i,
  input  logic [2:0]         cfg_mode_i,
  output logic               tick_o,
  output logic [NumLeds-1:0] pulse_busy_o,
  output logic [NumLeds-1:0] led_o
);

  typedef struct packed {
    logic            valid;
    logic [IdxW-1:0] idx;
    logic [2:0]      mode;
  } cfg_req_t;

  cfg_req_t                 req;
  logic [PrescaleWidth-1:0] presc_q;
  logic [2:0]               tick_cnt_q;
  logic                     idx_ok;
  logic                     mode_ok;
  logic                     accept;
  logic [NumLeds-1:0]       wr_en;

  assign req = '{valid: cfg_valid_i, idx: cfg_idx_i, mode: cfg_mode_i};

  assign tick_o = (presc_q == {PrescaleWidth{1'b1}});

  // Free-running prescaler.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) presc_q <= '0;
    else         presc_q <= presc_q + PrescaleWidth'(1);
  end

  // Blink phase counter shared by all lanes so they stay phase-aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     tick_cnt_q <= 3'd0;
    else if (tick_o) tick_cnt_q <= tick_cnt_q + 3'd1;
  end

  // Handshake: only abort (OFF) or retrigger (PULSE) may interrupt a pulse.
  // Out-of-range indices are always ready and simply dropped.
  always_comb begin
    idx_ok      = (int'(req.idx) < NumLeds);
    cfg_ready_o = 1'b1;
    if (idx_ok && pulse_busy_o[req.idx] && (req.mode != 3'd0) && (req.mode != 3'd4))
      cfg_ready_o = 1'b0;
  end

  // Reserved modes complete the handshake but leave the lane untouched.
`ifdef LED_CTRL_DIM_EN
  assign mode_ok = (req.mode <= 3'd5);
`else
  assign mode_ok = (req.mode <= 3'd4);
`endif

  assign accept = req.valid && cfg_ready_o && idx_ok && mode_ok;

`ifdef LED_CTRL_DIM_EN
  logic dim_phase;
  assign dim_phase = (presc_q[PrescaleWidth-1 -: 2] == 2'b00);
`endif

  for (genvar i = 0; i < NumLeds; i++) begin : g_lane
    assign wr_en[i] = accept && (int'(req.idx) == i);

    led_lane #(
      .PulseTicks (PulseTicks)
    ) u_lane (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_i      (wr_en[i]),
      .wr_mode_i (req.mode),
      .tick_i    (tick_o),
      .slow_i    (tick_cnt_q[2]),
      .fast_i    (tick_cnt_q[0]),
`ifdef LED_CTRL_DIM_EN
      .dim_i     (dim_phase),
`endif
      .busy_o    (pulse_busy_o[i]),
      .led_o     (led_o[i])
    );
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl (NumLeds=4, PrescaleWidth=2, PulseTicks=3).
// Cycle index cyc counts rising edges since reset release; tick cycles are cyc%4==3.
module tb_led_status_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [1:0] cfg_idx_i;
  logic [2:0] cfg_mode_i;
  logic       tick_o;
  logic [3:0] pulse_busy_o;
  logic [3:0] led_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  led_status_ctrl #(
    .NumLeds       (4),
    .PrescaleWidth (2),
    .PulseTicks    (3)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_idx_i    (cfg_idx_i),
    .cfg_mode_i   (cfg_mode_i),
    .tick_o       (tick_o),
    .pulse_busy_o (pulse_busy_o),
    .led_o        (led_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       v;
    logic [1:0] idx;
    logic [2:0] mode;
    logic       rdy;   // expected ready during the cycle
    logic [3:0] led;   // expected led_o after the edge
    logic [3:0] busy;  // expected pulse_busy_o after the edge
  } row_t;

  row_t tbl[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [1:0] idx, input logic [2:0] mode);
    cfg_valid_i = v;
    cfg_idx_i   = idx;
    cfg_mode_i  = mode;
  endtask

  task automatic probe(input logic [1:0] idx, input logic [2:0] mode, input logic exp, input string nm);
    drive(1'b0, idx, mode);
    #1;
    chk(nm, 32'(cfg_ready_o), 32'(exp));
  endtask

  initial begin
    logic [3:0] exp_led;
    logic       b0, b3;

    // ON/OFF latency, then a pulse with a held-off ON write, then an abort.
    tbl[0]  = '{1'b1, 2'd1, 3'd1, 1'b1, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 2'd0, 3'd0, 1'b1, 4'b0010, 4'b0000};
    tbl[2]  = '{1'b1, 2'd1, 3'd0, 1'b1, 4'b0010, 4'b0000};
    tbl[3]  = '{1'b0, 2'd0, 3'd0, 1'b1, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b1, 2'd2, 3'd4, 1'b1, 4'b0000, 4'b0100};
    tbl[5]  = '{1'b0, 2'd0, 3'd0, 1'b1, 4'b0100, 4'b0100};
    for (int k = 6; k <= 14; k++) tbl[k] = '{1'b1, 2'd2, 3'd1, 1'b0, 4'b0100, 4'b0100};
    tbl[15] = '{1'b1, 2'd2, 3'd1, 1'b0, 4'b0100, 4'b0000};
    tbl[16] = '{1'b1, 2'd2, 3'd1, 1'b1, 4'b0000, 4'b0000};
    tbl[17] = '{1'b0, 2'd0, 3'd0, 1'b1, 4'b0100, 4'b0000};
    tbl[18] = '{1'b1, 2'd2, 3'd4, 1'b1, 4'b0100, 4'b0100};
    tbl[19] = '{1'b0, 2'd0, 3'd0, 1'b1, 4'b0100, 4'b0100};
    tbl[20] = '{1'b1, 2'd2, 3'd0, 1'b1, 4'b0100, 4'b0000};
    tbl[21] = '{1'b0, 2'd0, 3'd0, 1'b1, 4'b0000, 4'b0000};

    // Reset state
    rst_ni = 1'b0;
    drive(1'b0, 2'd0, 3'd0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_led",   32'(led_o),        32'h0);
    chk("rst_busy",  32'(pulse_busy_o), 32'h0);
    chk("rst_ready", 32'(cfg_ready_o),  32'h1);
    chk("rst_tick",  32'(tick_o),       32'h0);
    rst_ni = 1'b1;
    cyc    = 0;

    // Table-driven section, cycles 0..21
    for (int k = 0; k < 22; k++) begin
      drive(tbl[k].v, tbl[k].idx, tbl[k].mode);
      #1;
      chk($sformatf("tbl%0d_ready", k), 32'(cfg_ready_o), 32'(tbl[k].rdy));
      step();
      chk($sformatf("tbl%0d_led", k),  32'(led_o),        32'(tbl[k].led));
      chk($sformatf("tbl%0d_busy", k), 32'(pulse_busy_o), 32'(tbl[k].busy));
      chk($sformatf("tbl%0d_tick", k), 32'(tick_o),       32'((cyc % 4) == 3));
    end

    // Retrigger collision: PULSE rewrite on the tick where the counter is 1.
    drive(1'b1, 2'd2, 3'd4);
    #1;
    chk("coll_start_ready", 32'(cfg_ready_o), 32'h1);
    step();
    drive(1'b0, 2'd0, 3'd0);
    for (int c = 23; c <= 45; c++) begin
      if (c >= 24) chk("coll_led", 32'(led_o), (c <= 44) ? 32'h4 : 32'h0);
      chk("coll_busy", 32'(pulse_busy_o), (c < 44) ? 32'h4 : 32'h0);
      if (c == 25) begin
        probe(2'd2, 3'd1, 1'b0, "busy_on_blocked");
        probe(2'd2, 3'd2, 1'b0, "busy_slow_blocked");
        probe(2'd2, 3'd0, 1'b1, "busy_off_ok");
        probe(2'd2, 3'd4, 1'b1, "busy_pulse_ok");
        probe(2'd1, 3'd1, 1'b1, "other_lane_ok");
        drive(1'b0, 2'd0, 3'd0);
      end
      if (c == 31) begin
        chk("coll_tick", 32'(tick_o), 32'h1);
        drive(1'b1, 2'd2, 3'd4);
        #1;
        chk("coll_retrig_ready", 32'(cfg_ready_o), 32'h1);
      end
      step();
      drive(1'b0, 2'd0, 3'd0);
    end

    // Blink: idx0 fast, idx3 slow, both phase-aligned to the tick counter.
    drive(1'b1, 2'd0, 3'd3);
    step();
    drive(1'b1, 2'd3, 3'd2);
    step();
    drive(1'b0, 2'd0, 3'd0);
    while (cyc < 89) begin
      step();
      b0 = 1'(((cyc - 1) / 4) % 2);
      b3 = 1'(((cyc - 1) / 16) % 2);
      chk("blink_led", 32'(led_o), 32'({b3, 2'b00, b0}));
    end

    // Mode 7 never changes state; mode 5 depends on the DIM build option.
    drive(1'b1, 2'd1, 3'd1);
    step();
    drive(1'b1, 2'd1, 3'd7);
    #1;
    chk("mode7_ready", 32'(cfg_ready_o), 32'h1);
    step();
    drive(1'b1, 2'd0, 3'd5);
    #1;
    chk("mode5_ready", 32'(cfg_ready_o), 32'h1);
    step();
    drive(1'b0, 2'd0, 3'd0);
    while (cyc < 110) begin
      step();
`ifdef LED_CTRL_DIM_EN
      b0 = ((cyc - 1) % 4) == 0;
`else
      b0 = 1'(((cyc - 1) / 4) % 2);
`endif
      b3 = 1'(((cyc - 1) / 16) % 2);
      exp_led = {b3, 2'b01, b0};
      chk("cfg_led", 32'(led_o), 32'(exp_led));
    end

    // Reset in the middle of a pulse aborts it with no resume.
    drive(1'b1, 2'd2, 3'd4);
    step();
    drive(1'b0, 2'd0, 3'd0);
    step();
    chk("pre_rst_busy", 32'(pulse_busy_o), 32'h4);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_busy", 32'(pulse_busy_o), 32'h0);
    chk("midrst_led",  32'(led_o),        32'h0);
    probe(2'd2, 3'd1, 1'b1, "midrst_ready");
    chk("midrst_tick", 32'(tick_o), 32'h0);
    drive(1'b0, 2'd0, 3'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cyc    = 0;
    repeat (8) begin
      step();
      chk("postrst_busy", 32'(pulse_busy_o), 32'h0);
      chk("postrst_led",  32'(led_o),        32'h0);
      chk("postrst_tick", 32'(tick_o),       32'((cyc % 4) == 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_status_ctrl.md
# led_status_ctrl

Sequencing controller for a bank of registered LED indicators in the liberty74 merged-cell flow. It holds a per-LED display mode (off, on, slow/fast blink, timed one-shot pulse) written over a valid/ready configuration port. It generates a shared prescaled tick and drives one registered data bit per LED. Each `led_o` bit feeds the data input of one reset-able flip-flop + LED merge cell, so no blink or timing logic lives in the indicator cells.

## Interface
- `NumLeds`, default 4: number of driven indicators; must be ≥ 2.
- `PrescaleWidth`, default 8: prescaler width; tick period is 2^PrescaleWidth cycles; must be ≥ 2.
- `PulseTicks`, default 8: one-shot pulse length in ticks; must be 1..255.
- `clk_i`  in  1  system clock; all state on its rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `cfg_valid_i`  in  1  configuration write request.
- `cfg_ready_o`  out  1  write can be accepted this cycle.
- `cfg_idx_i`  in  $clog2(NumLeds)  target LED index.
- `cfg_mode_i`  in  3  requested mode.
- `tick_o`  out  1  one-cycle strobe at each prescaler wrap.
- `pulse_busy_o`  out  NumLeds  per-LED: one-shot pulse in progress.
- `led_o`  out  NumLeds  registered LED data, one bit per indicator cell.

## Operation
- Modes:
  - 0 OFF
  - 1 ON
  - 2 BLINK_SLOW
  - 3 BLINK_FAST
  - 4 PULSE
  - 5 DIM (see Configuration)
  - 6–7 reserved
- Reserved-mode write: handshake completes, stored mode unchanged.
- Out-of-range `cfg_idx_i` (≥ NumLeds): handshake completes, no state changes.
- Prescaler `presc_q`: free-running, width PrescaleWidth. `tick_o = (presc_q == all-ones)`.
- `tick_cnt_q`: 3-bit, increments on every tick and wraps 7→0. All LEDs blink phase-aligned to it.
- Per-LED output value, computed from the current `mode_q[i]`:
  - OFF = 0
  - ON = 1
  - BLINK_SLOW = `tick_cnt_q[2]` (toggles every 4 ticks)
  - BLINK_FAST = `tick_cnt_q[0]` (toggles every tick)
  - PULSE = 1
- PULSE sequence:
  - Accepting PULSE loads `pcnt_q[i] = PulseTicks` and sets `pulse_busy_o[i]`.
  - Each tick decrements `pcnt_q[i]`.
  - On the tick where `pcnt_q[i] == 1`: mode becomes OFF, counter becomes 0, busy clears.
- Handshake:
  - Accept = `cfg_valid_i && cfg_ready_o`.
  - `cfg_ready_o` depends only on `cfg_idx_i`, `cfg_mode_i` and state, never on `cfg_valid_i`.
  - `cfg_ready_o = 0` iff `pulse_busy_o[cfg_idx_i]` is set and `cfg_mode_i` is not OFF and not PULSE.
  - So during a pulse, only an abort (OFF) or a retrigger (PULSE, which reloads `PulseTicks`) is accepted.
- Simultaneous write and tick on the same LED: the write wins. The counter is loaded, not decremented, and the mode is the written one.
- Writes to different LEDs never interact.

## Timing
- Reset values (asynchronous, while `rst_ni` low):
  - all `mode_q` = OFF, `pcnt_q` = 0, `presc_q` = 0, `tick_cnt_q` = 0
  - `led_o` = 0, `pulse_busy_o` = 0, `tick_o` = 0
  - `cfg_ready_o` = 1 (no pulse is busy)
- Reset mid-pulse: pulse aborted immediately; no resume after release.
- Write accepted at edge N: `mode_q` updates at edge N. `led_o` reflects the new mode at edge N+1. The indicator cell shows it at edge N+2.
- `pulse_busy_o` rises at edge N (combinational from `pcnt_q != 0`).
- First tick after reset release: cycle 2^PrescaleWidth − 1.
- PULSE on-time: between PulseTicks−1 and PulseTicks tick periods, depending on phase at accept; `led_o` falls one cycle after busy clears.

## Configuration
- Macro `LED_CTRL_DIM_EN`.
- Defined:
  - Mode 5 DIM is valid: LED value = (`presc_q[PrescaleWidth-1:PrescaleWidth-2] == 2'b00`), a 25 % duty PWM at tick rate.
  - DIM is accepted like any non-pulse mode.
- Undefined:
  - Mode 5 is reserved: write accepted, mode unchanged.
  - No DIM decode logic is synthesised.

## Test plan
All scenarios use NumLeds=4, PrescaleWidth=2 (tick every 4 cycles), PulseTicks=3.
- Reset: hold `rst_ni` low, then release → `led_o`=0000, `pulse_busy_o`=0000, `cfg_ready_o`=1; first `tick_o` in cycle 3, then every 4 cycles.
- ON/OFF latency: write idx1 mode1 accepted at edge N → `led_o`=0010 at edge N+1; write idx1 mode0 → back to 0000 one edge after accept.
- Blink: idx0 BLINK_FAST and idx3 BLINK_SLOW → `led_o[0]` toggles every 4 cycles; `led_o[3]` toggles every 16 cycles, high when `tick_cnt_q` ≥ 4.
- Pulse and blocking:
  - idx2 PULSE → busy for exactly 3 ticks, `led_o[2]` high meanwhile.
  - Write idx2 mode1 during the pulse → `cfg_ready_o`=0, held off until busy clears, then accepted.
  - Write idx2 mode0 mid-pulse → accepted; LED off next edge.
- Retrigger collision: PULSE rewrite to idx2 in the same cycle as `tick_o` with `pcnt_q`=1 → `pcnt_q`=3, busy stays high, no OFF glitch on `led_o[2]`.
- Config: with `LED_CTRL_DIM_EN`, idx0 mode5 → `led_o[0]` high 1 of every 4 cycles. Without it, the same write leaves the prior mode intact. Mode 7 never alters state in either build.
